// File: rtl/bc_en_rc_pipe.sv
// bc_en_rc_pipe: DEPTH-stage retiming pipeline with valid/ready handshake.
// Empty stages (bubbles) are filled as soon as anything can move into them,
// so the pipeline holds up to DEPTH entries under backpressure and passes
// one entry per cycle when downstream is always ready. iFlush drops every
// entry synchronously; rst clears everything asynchronously.
// Input data is zero-extended or truncated to WIDTH_OUT at stage 0.
// Optional build macro: BC_EN_RC_PIPE_CNT_EN adds the oCnt occupancy output.

module bc_en_rc_pipe #(
   parameter int                   WIDTH_IN  = 32,
   parameter int                   WIDTH_OUT = 32,
   parameter int                   DEPTH     = 3,
   parameter logic [WIDTH_OUT-1:0] INI_DATA  = '0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 iFlush,
   input  logic                 iVld,
   output logic                 oRdy,
   input  logic [WIDTH_IN-1:0]  iDat,
   output logic                 oVld,
   input  logic                 iRdy,
   output logic [WIDTH_OUT-1:0] oDat,
   output logic                 oEmpty
`ifdef BC_EN_RC_PIPE_CNT_EN
   ,
   output logic [$clog2(DEPTH+1)-1:0] oCnt
`endif
);

   logic [DEPTH-1:0]     stageVld_r;
   logic [WIDTH_OUT-1:0] stageDat_r [DEPTH];
   logic [DEPTH-1:0]     stageEn_s;
   logic [WIDTH_OUT-1:0] adaptDat_s;

   // Stage 0 width adaptation: keep the LSBs when narrowing, zero-extend when widening.
   generate
      if (WIDTH_IN >= WIDTH_OUT) begin : gNarrow
         assign adaptDat_s = iDat[WIDTH_OUT-1:0];
         if (WIDTH_IN > WIDTH_OUT) begin : gDropHi
            logic unusedHi_s;
            assign unusedHi_s = ^iDat[WIDTH_IN-1:WIDTH_OUT];
         end
      end else begin : gWiden
         assign adaptDat_s = {{(WIDTH_OUT-WIDTH_IN){1'b0}}, iDat};
      end
   endgenerate

   // Stage k may load when downstream is ready or any stage at or beyond k is
   // empty; this is the unrolled form of en[k] = !vld[k] | en[k+1].
   always_comb begin
      stageEn_s = '0;
      for (int k = 0; k < DEPTH; k++) begin
         logic hole;
         hole = 1'b0;
         for (int j = k; j < DEPTH; j++) begin
            hole = hole | ~stageVld_r[j];
         end
         stageEn_s[k] = iRdy | hole;
      end
   end

   assign oRdy   = stageEn_s[0] & ~iFlush;
   assign oVld   = stageVld_r[DEPTH-1];
   assign oDat   = stageDat_r[DEPTH-1];
   assign oEmpty = ~|stageVld_r;

   // Pipeline state: flush invalidates every stage, otherwise each enabled
   // stage takes its predecessor; data only loads behind a valid flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stageVld_r <= '0;
         for (int k = 0; k < DEPTH; k++) begin
            stageDat_r[k] <= INI_DATA;
         end
      end else if (iFlush) begin
         stageVld_r <= '0;
      end else begin
         if (stageEn_s[0]) begin
            stageVld_r[0] <= iVld;
            if (iVld) begin
               stageDat_r[0] <= adaptDat_s;
            end
         end
         for (int k = 1; k < DEPTH; k++) begin
            if (stageEn_s[k]) begin
               stageVld_r[k] <= stageVld_r[k-1];
               if (stageVld_r[k-1]) begin
                  stageDat_r[k] <= stageDat_r[k-1];
               end
            end
         end
      end
   end

`ifdef BC_EN_RC_PIPE_CNT_EN
   localparam int CW = $clog2(DEPTH+1);

   logic [CW-1:0] cnt_r;
   logic          upXfer_s;
   logic          dnXfer_s;

   assign upXfer_s = iVld & oRdy;
   assign dnXfer_s = oVld & iRdy;
   assign oCnt     = cnt_r;

   // Occupancy count: tracks accepted minus delivered entries, cleared on flush.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_r <= '0;
      end else if (iFlush) begin
         cnt_r <= '0;
      end else if (upXfer_s && !dnXfer_s) begin
         cnt_r <= cnt_r + CW'(1);
      end else if (!upXfer_s && dnXfer_s) begin
         cnt_r <= cnt_r - CW'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end
`endif

endmodule

// File: tb/tb_bc_en_rc_pipe.sv
// Bench for bc_en_rc_pipe: directed test-plan scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// queue-based model of in-flight entries.

module tb_bc_en_rc_pipe;

   localparam int          DEPTH = 3;
   localparam logic [31:0] INI   = 32'h1;

   logic        clk = 1'b0;
   logic        rst, iFlush, iVld, iRdy;
   logic [31:0] iDat;
   logic        oRdy, oVld, oEmpty;
   logic [31:0] oDat;

   // narrow-to-wide and wide-to-narrow instances
   logic        wRdy, wFlush;
   logic        wVldU, wVldD;
   logic [7:0]  wDatU;
   logic [11:0] wDatD;
   logic        wORdyU, wOVldU, wOEmptyU;
   logic [11:0] wODatU;
   logic        wORdyD, wOVldD, wOEmptyD;
   logic [7:0]  wODatD;

`ifdef BC_EN_RC_PIPE_CNT_EN
   logic [1:0]  oCnt;
   logic [1:0]  wOCntU;
   logic [0:0]  wOCntD;
`endif

   always #5 clk = ~clk;

   bc_en_rc_pipe #(.WIDTH_IN(32), .WIDTH_OUT(32), .DEPTH(DEPTH), .INI_DATA(INI)) dut (
      .clk(clk), .rst(rst), .iFlush(iFlush), .iVld(iVld), .oRdy(oRdy), .iDat(iDat),
      .oVld(oVld), .iRdy(iRdy), .oDat(oDat), .oEmpty(oEmpty)
`ifdef BC_EN_RC_PIPE_CNT_EN
      , .oCnt(oCnt)
`endif
   );

   bc_en_rc_pipe #(.WIDTH_IN(8), .WIDTH_OUT(12), .DEPTH(3)) dutUp (
      .clk(clk), .rst(rst), .iFlush(wFlush), .iVld(wVldU), .oRdy(wORdyU), .iDat(wDatU),
      .oVld(wOVldU), .iRdy(wRdy), .oDat(wODatU), .oEmpty(wOEmptyU)
`ifdef BC_EN_RC_PIPE_CNT_EN
      , .oCnt(wOCntU)
`endif
   );

   bc_en_rc_pipe #(.WIDTH_IN(12), .WIDTH_OUT(8), .DEPTH(1)) dutDn (
      .clk(clk), .rst(rst), .iFlush(wFlush), .iVld(wVldD), .oRdy(wORdyD), .iDat(wDatD),
      .oVld(wOVldD), .iRdy(wRdy), .oDat(wODatD), .oEmpty(wOEmptyD)
`ifdef BC_EN_RC_PIPE_CNT_EN
      , .oCnt(wOCntD)
`endif
   );

   int nChk  = 0;
   int nPass = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      nChk++;
      if (act === exp) nPass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   // Model: list of in-flight entries, oldest first, each with its stage index.
   typedef struct {
      logic [31:0] d;
      int          pos;
   } ent_t;
   ent_t q[$];

   // Upstream accepts unless flushing, or all DEPTH slots are taken and nothing leaves.
   function automatic bit mRdy();
      return !iFlush && (iRdy || q.size() < DEPTH);
   endfunction

   // Model update: oldest leaves if downstream ready; every other entry moves
   // forward unless the entries ahead already fill every slot ahead of it.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         q.delete();
      end else begin
         automatic ent_t nq[$];
         automatic ent_t e;
         automatic bit   acc;
         acc = iVld && mRdy();
         if (!iFlush) begin
            for (int i = 0; i < q.size(); i++) begin
               e = q[i];
               if (e.pos == DEPTH-1) begin
                  if (!iRdy) nq.push_back(e);
               end else begin
                  if (iRdy || i < DEPTH - (e.pos + 1)) e.pos++;
                  nq.push_back(e);
               end
            end
            if (acc) begin
               e.d   = iDat;
               e.pos = 0;
               nq.push_back(e);
            end
         end
         q = nq;
      end
   end

   // Per-cycle comparison of all outputs against the model.
   always @(negedge clk) begin
      if (rst) begin
         automatic bit ev;
         ev = (q.size() > 0) && (q[0].pos == DEPTH-1);
         chk("m_oVld", oVld, ev);
         if (ev) chk("m_oDat", oDat, q[0].d);
         chk("m_oEmpty", oEmpty, q.size() == 0);
         chk("m_oRdy", oRdy, mRdy());
`ifdef BC_EN_RC_PIPE_CNT_EN
         chk("m_oCnt", oCnt, q.size());
`endif
      end
   end

   // Delivery log used by the directed scenarios.
   logic [31:0] gotQ[$];
   int          gotCyc[$];
   int          cycNo = 0;

   always @(posedge clk) cycNo <= cycNo + 1;

   always @(negedge clk) begin
      if (rst && oVld && iRdy) begin
         gotQ.push_back(oDat);
         gotCyc.push_back(cycNo);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int idx;
      rst = 1'b0; iFlush = 1'b0; iVld = 1'b0; iRdy = 1'b0; iDat = 32'h0;
      wRdy = 1'b0; wFlush = 1'b0; wVldU = 1'b0; wVldD = 1'b0; wDatU = 8'h0; wDatD = 12'h0;

      // reset
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("rst_oVld", oVld, 1'b0);
      chk("rst_oDat", oDat, 32'h1);
      chk("rst_oEmpty", oEmpty, 1'b1);
      chk("rst_oRdy", oRdy, 1'b1);
`ifdef BC_EN_RC_PIPE_CNT_EN
      chk("rst_oCnt", oCnt, 2'd0);
`endif

      // streaming
      iRdy = 1'b1;
      gotQ.delete(); gotCyc.delete();
      for (int i = 0; i < 10; i++) begin
         iVld = 1'b1;
         iDat = 32'hA0 + i;
         cyc();
         if (i < 2) chk("stream_lat_lo", oVld, 1'b0);
         if (i == 2) begin
            chk("stream_lat_hi", oVld, 1'b1);
            chk("stream_first", oDat, 32'hA0);
         end
      end
      iVld = 1'b0;
      repeat (5) cyc();
      chk("stream_cnt", gotQ.size(), 10);
      for (int j = 0; j < gotQ.size() && j < 10; j++) begin
         chk("stream_data", gotQ[j], 32'hA0 + j);
         chk("stream_gap", gotCyc[j] - gotCyc[0], j);
      end

      // backpressure
      iRdy = 1'b0;
      gotQ.delete(); gotCyc.delete();
      idx = 0;
      for (int c = 0; c < 6; c++) begin
         iVld = 1'b1;
         iDat = 32'hA0 + idx;
         @(negedge clk);
         if (oRdy) idx++;
         cyc();
      end
      chk("bp_accepted", idx, 3);
      chk("bp_oRdy", oRdy, 1'b0);
      chk("bp_oVld", oVld, 1'b1);
      chk("bp_oDat", oDat, 32'hA0);
`ifdef BC_EN_RC_PIPE_CNT_EN
      chk("bp_oCnt", oCnt, 2'd3);
`endif
      iRdy = 1'b1;
      for (int c = 0; c < 20 && idx < 5; c++) begin
         iVld = 1'b1;
         iDat = 32'hA0 + idx;
         @(negedge clk);
         if (oRdy) idx++;
         cyc();
      end
      iVld = 1'b0;
      chk("bp_sent", idx, 5);
      repeat (6) cyc();
      chk("bp_cnt", gotQ.size(), 5);
      for (int j = 0; j < gotQ.size() && j < 5; j++) chk("bp_data", gotQ[j], 32'hA0 + j);

      // bubble collapse
      iRdy = 1'b0;
      gotQ.delete(); gotCyc.delete();
      iVld = 1'b1; iDat = 32'hA0; cyc();
      iVld = 1'b0; cyc(); cyc();
      iVld = 1'b1; iDat = 32'hA1; cyc();
      iVld = 1'b0; cyc(); cyc();
      chk("bub_oVld", oVld, 1'b1);
      chk("bub_oDat", oDat, 32'hA0);
      chk("bub_oEmpty", oEmpty, 1'b0);
`ifdef BC_EN_RC_PIPE_CNT_EN
      chk("bub_oCnt", oCnt, 2'd2);
`endif
      iRdy = 1'b1;
      repeat (4) cyc();
      chk("bub_cnt", gotQ.size(), 2);
      if (gotQ.size() == 2) begin
         chk("bub_first", gotQ[0], 32'hA0);
         chk("bub_second", gotQ[1], 32'hA1);
         chk("bub_gap", gotCyc[1] - gotCyc[0], 1);
      end

      // flush
      iRdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         iVld = 1'b1;
         iDat = 32'hB0 + i;
         cyc();
      end
      chk("fl_full_oRdy", oRdy, 1'b0);
      iFlush = 1'b1; iVld = 1'b1; iDat = 32'hBEEF;
      @(negedge clk);
      chk("fl_oRdy", oRdy, 1'b0);
      cyc();
      iFlush = 1'b0; iVld = 1'b0;
      #1;
      chk("fl_oVld", oVld, 1'b0);
      chk("fl_oEmpty", oEmpty, 1'b1);
`ifdef BC_EN_RC_PIPE_CNT_EN
      chk("fl_oCnt", oCnt, 2'd0);
`endif
      gotQ.delete(); gotCyc.delete();
      iRdy = 1'b1;
      repeat (5) cyc();
      chk("fl_no_output", gotQ.size(), 0);

      // randomized traffic
      for (int c = 0; c < 600; c++) begin
         iVld   = 1'($urandom_range(0, 1));
         iDat   = $urandom;
         iRdy   = (c < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
         iFlush = ($urandom_range(0, 15) == 0);
         cyc();
      end

      // asynchronous reset mid-operation
      iFlush = 1'b0; iVld = 1'b1; iRdy = 1'b0; iDat = 32'h5A5A;
      repeat (3) cyc();
      #3 rst = 1'b0;
      #1;
      chk("mrst_oVld", oVld, 1'b0);
      chk("mrst_oEmpty", oEmpty, 1'b1);
      chk("mrst_oDat", oDat, INI);
      @(posedge clk);
      #1 rst = 1'b1;
      iVld = 1'b0;
      repeat (2) cyc();

      // width adaptation
      wVldU = 1'b1; wDatU = 8'hFF;
      wVldD = 1'b1; wDatD = 12'hABC;
      cyc();
      wVldU = 1'b0; wVldD = 1'b0;
      chk("wdn_oVld", wOVldD, 1'b1);
      chk("wdn_oDat", wODatD, 8'hBC);
      cyc(); cyc();
      chk("wup_oVld", wOVldU, 1'b1);
      chk("wup_oDat", wODatU, 12'h0FF);

      $display("%0d/%0d checks passed", nPass, nChk);
      $finish;
   end

endmodule

// File: doc/bc_en_rc_pipe.md
Name: bc_en_rc_pipe

Overview:
- Parametrised successor to the single-stage enabled, reset-configurable DFF.
- Implements a DEPTH-stage register pipeline with a valid/ready handshake, per-stage bubble collapsing, synchronous flush and input-to-output width adaptation.
- Used wherever a datapath needs N cycles of retiming that can stall under backpressure without losing or duplicating data.

Parameters:
- WIDTH_IN, 32, input data width (>=1).
- WIDTH_OUT, 32, output data width (>=1).
- DEPTH, 3, number of register stages (>=1); also the maximum number of entries held.
- INI_DATA, '0, reset value of every stage data register (WIDTH_OUT bits).

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  reset; asynchronous assert, active-low; synchronous deassert is the system's responsibility.
- iFlush  input  1  synchronous flush; invalidates all stages.
- iVld  input  1  upstream data valid.
- oRdy  output  1  upstream ready; combinational.
- iDat  input  WIDTH_IN  upstream data.
- oVld  output  1  downstream data valid; equals the last stage's valid flag.
- iRdy  input  1  downstream ready.
- oDat  output  WIDTH_OUT  downstream data; equals the last stage's data register.
- oEmpty  output  1  high when no stage holds valid data; combinational from the valid flags.

Behaviour:
- State: vld[k] (1 bit) and dat[k] (WIDTH_OUT bits) for k = 0..DEPTH-1. Stage 0 is the input side.
- Reset (rst=0, asynchronous): every vld[k] = 0; every dat[k] = INI_DATA. Hence oVld = 0, oDat = INI_DATA, oEmpty = 1, and oRdy = 1 if iFlush = 0.
- Stage enables, combinational chain:
  - en[DEPTH-1] = !vld[DEPTH-1] | iRdy.
  - en[k] = !vld[k] | en[k+1].
  - Result: a stage accepts new contents whenever it is empty or its contents move on. Bubbles collapse, and throughput is one entry per cycle under continuous iRdy.
- Advance on each rising edge when en[k] = 1:
  - vld[k] <= (k==0 ? iVld : vld[k-1]).
  - dat[k] loads (k==0 ? adapted iDat : dat[k-1]) only when the incoming valid is 1; otherwise dat[k] holds its old value.
- When en[k] = 0, vld[k] and dat[k] hold.
- Width adaptation at stage 0 only:
  - WIDTH_IN < WIDTH_OUT: zero-extend.
  - WIDTH_IN > WIDTH_OUT: keep the LSBs.
- Handshakes:
  - Upstream transfer when iVld & oRdy. oRdy = en[0] & !iFlush.
  - Downstream transfer when oVld & iRdy.
  - iVld must not depend on oRdy.
  - oVld/oDat stay stable while oVld & !iRdy.
- Latency: an entry accepted at edge t appears on oVld/oDat after edge t+DEPTH-1, i.e. DEPTH cycles from iVld to oVld with no stall.
- Full: all vld = 1 and iRdy = 0 gives oRdy = 0. If all stages are valid and iRdy = 1, oRdy = 1: full-throughput pass-through, with simultaneous in and out in the same cycle.
- Flush (iFlush = 1 at an edge):
  - All vld[k] <= 0; dat registers hold.
  - oRdy = 0 during the flush cycle, so no input is accepted.
  - A downstream handshake in that cycle still counts as delivered.
  - Flush has priority over advance.
- Reset mid-operation: all data is discarded immediately (asynchronous); no partial outputs.
- DEPTH = 1 degenerates to a single enabled register with the same handshake rules.

Optional Feature:
- Macro: BC_EN_RC_PIPE_CNT_EN.
- Defined: adds output port oCnt, width $clog2(DEPTH+1), a registered occupancy count.
  - Reset value 0.
  - Next value: 0 on flush; otherwise +1 on an upstream transfer, -1 on a downstream transfer, unchanged when both or neither occur.
  - oCnt always equals the number of set vld bits, after the edge; the bench asserts this.
- Undefined: no oCnt port and no counter logic. All other behaviour is identical.

Test Plan (DEPTH=3, WIDTH_IN=WIDTH_OUT=32, INI_DATA=32'h1 unless noted):
- Reset check: hold rst=0 for 2 cycles, then release -> oVld=0, oDat=32'h1, oEmpty=1, oRdy=1; oCnt=0 if enabled.
- Streaming: iRdy=1, send 32'hA0..32'hA9 on consecutive cycles -> oVld rises 3 cycles after the first accept; outputs A0..A9 in order, back to back, with no gaps.
- Backpressure: iRdy=0 while sending A0..A4 -> exactly 3 accepted, oRdy=0 from then on, oDat=A0 stable. Raise iRdy -> A0..A4 delivered in order; oCnt peaks at 3.
- Bubble collapse: send A0, idle 2 cycles, send A1 while iRdy=0 -> A0 and A1 both held (oCnt=2, oEmpty=0). Release iRdy -> A0 then A1 on consecutive cycles.
- Flush: 3 entries held, pulse iFlush with iVld=1 and iDat=BEEF -> next cycle oVld=0, oEmpty=1, oCnt=0, and BEEF is never output.
- Width adapt: WIDTH_IN=8, WIDTH_OUT=12, send 8'hFF -> oDat=12'h0FF. With WIDTH_IN=12, WIDTH_OUT=8, send 12'hABC -> oDat=8'hBC.
